// File: rtl/mio_bus_ctrl_if.sv
// CPU data-port bus between the core and the memory/IO controller.
// The controller uses the slave view; the CPU (or a bench) uses the master view.
interface mio_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        bus_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, bus_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU accesses to block RAM (with wait states),
// a GPIO port and a free-running 32-bit timer whose wrap raises int_out.
module mio_bus_ctrl #(
  parameter int RAM_WAIT = 2,
  parameter int ADDR_W   = 10,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mio_bus_ctrl_if.slave     cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_en,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              int_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  RGN_RAM       = 4'h0;
  localparam logic [3:0]  RGN_GPIO      = 4'hE;
  localparam logic [3:0]  RGN_TMR       = 4'hF;
  localparam logic [3:0]  WAIT_LAST     = 4'(RAM_WAIT - 1);
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  state_t            state_r, state_s;
  logic [3:0]        wait_cnt_r, wait_cnt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              we_r;
  logic [31:0]       cap_r;
  logic              accept_s;
  logic              ram_en_s, ram_we_s, done_s, err_s, led_wr_s, tmr_wr_s;
  logic [31:0]       rdata_s;
  logic              ram_en_r, ram_we_r, ready_r, err_r, int_r;
  logic [31:0]       rdata_r, timer_r;
  logic [LED_W-1:0]  led_r;
  logic              unused_s;

  assign accept_s  = (state_r == ST_IDLE) && cpu.cpu_req;
  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign led_out   = led_r;
  assign int_out   = int_r;
  assign cpu.cpu_rdata = rdata_r;
  assign cpu.cpu_ready = ready_r;
  assign cpu.bus_err   = err_r;
  // Address bits outside the RAM word index and the GPIO offset alias away.
  assign unused_s = ^{cpu.cpu_addr[27:ADDR_W+2], cpu.cpu_addr[1:0]};

  // Next-state and per-transition strobes; IO accesses resolve on the accept edge.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    ram_en_s   = 1'b0;
    ram_we_s   = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    led_wr_s   = 1'b0;
    tmr_wr_s   = 1'b0;
    rdata_s    = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (cpu.cpu_req) begin
          case (cpu.cpu_addr[31:28])
            RGN_RAM: begin
              state_s  = ST_ACCESS;
              ram_en_s = 1'b1;
              ram_we_s = cpu.cpu_we;
            end
            RGN_GPIO: begin
              state_s = ST_DONE;
              done_s  = 1'b1;
              if (cpu.cpu_we) begin
                led_wr_s = ~cpu.cpu_addr[2];
              end else if (cpu.cpu_addr[2]) begin
                rdata_s = 32'(led_r);
              end else begin
                rdata_s = 32'(sw_in);
              end
            end
            RGN_TMR: begin
              state_s = ST_DONE;
              done_s  = 1'b1;
              if (cpu.cpu_we) begin
                tmr_wr_s = 1'b1;
              end else begin
                rdata_s = timer_r;
              end
            end
            default: begin
              state_s = ST_DONE;
              done_s  = 1'b1;
              err_s   = 1'b1;
              rdata_s = cpu.cpu_we ? 32'd0 : UNMAPPED_DATA;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (RAM_WAIT > 0) begin
          state_s    = ST_WAIT;
          wait_cnt_s = 4'd0;
        end else begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          rdata_s = we_r ? 32'd0 : ram_rdata;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s    = ST_DONE;
          done_s     = 1'b1;
          wait_cnt_s = 4'd0;
          rdata_s    = we_r ? 32'd0 : cap_r;
        end else begin
          wait_cnt_s = wait_cnt_r + 4'd1;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, wait counter, latched request and captured RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      cap_r      <= 32'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (accept_s) begin
        addr_r  <= cpu.cpu_addr[ADDR_W+1:2];
        wdata_r <= cpu.cpu_wdata;
        we_r    <= cpu.cpu_we;
      end
      if (state_r == ST_ACCESS) begin
        cap_r <= ram_rdata;
      end
    end
  end

  // Registered bus and RAM strobes so every output is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_r <= 1'b0;
      ram_we_r <= 1'b0;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      ram_en_r <= ram_en_s;
      ram_we_r <= ram_we_s;
      ready_r  <= done_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= {LED_W{1'b0}};
    end else if (led_wr_s) begin
      led_r <= cpu.cpu_wdata[LED_W-1:0];
    end
  end

  // Timer: a CPU load replaces the increment and never counts as a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= 32'd0;
      int_r   <= 1'b0;
    end else if (tmr_wr_s) begin
      timer_r <= cpu.cpu_wdata;
      int_r   <= 1'b0;
    end else begin
      timer_r <= timer_r + 32'd1;
      int_r   <= (timer_r == 32'hFFFF_FFFF);
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: two instances (RAM_WAIT=2 and RAM_WAIT=0) driven with directed
// and random transactions, checked against a transaction-level memory/LED/timer model.
module tb_mio_bus_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_d [2];
  logic        we_d [2];
  logic [31:0] addr_d [2];
  logic [31:0] wdata_d [2];
  logic [31:0] rdata_v [2];
  logic        ready_v [2];
  logic        err_v [2];
  logic [AW-1:0] ram_addr_v [2];
  logic [31:0] ram_wdata_v [2];
  logic [31:0] ram_rdata_v [2];
  logic        ram_en_v [2];
  logic        ram_we_v [2];
  logic [15:0] led_v [2];
  logic        int_v [2];
  logic [15:0] sw;
  int          en_cnt [2] = '{0, 0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mio_bus_ctrl_if bus ();
    logic [31:0] mem [1024];

    assign bus.cpu_req   = req_d[g];
    assign bus.cpu_we    = we_d[g];
    assign bus.cpu_addr  = addr_d[g];
    assign bus.cpu_wdata = wdata_d[g];
    assign rdata_v[g]    = bus.cpu_rdata;
    assign ready_v[g]    = bus.cpu_ready;
    assign err_v[g]      = bus.bus_err;
    assign ram_rdata_v[g] = mem[ram_addr_v[g]];

    always @(posedge clk) begin
      if (ram_en_v[g] && ram_we_v[g]) mem[ram_addr_v[g]] <= ram_wdata_v[g];
    end

    mio_bus_ctrl #(.RAM_WAIT(g == 0 ? 2 : 0), .ADDR_W(AW), .LED_W(16), .SW_W(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu       (bus),
      .ram_addr  (ram_addr_v[g]),
      .ram_wdata (ram_wdata_v[g]),
      .ram_en    (ram_en_v[g]),
      .ram_we    (ram_we_v[g]),
      .ram_rdata (ram_rdata_v[g]),
      .sw_in     (sw),
      .led_out   (led_v[g]),
      .int_out   (int_v[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) if (ram_en_v[k]) en_cnt[k] <= en_cnt[k] + 1;
  end

  // Reference model state
  logic [31:0] ref_mem [2][16];
  logic [15:0] ref_led [2];
  logic [31:0] tbase [2];
  int          tcyc [2];
  int          wait_of [2] = '{2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_a(input int w);
    return {4'h0, 16'($urandom), 6'd0, 4'(w), 2'($urandom)};
  endfunction

  task automatic idle(input int n);
    req_d[0] = 1'b0;
    req_d[1] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      ref_led[k] = 16'd0;
      tbase[k]   = 32'd0;
      tcyc[k]    = cyc;
    end
  endtask

  // One CPU transaction; b2b means it is issued in the DONE cycle of the previous one.
  task automatic xact(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit b2b, input bit scram, output logic [31:0] got, output int lat);
    logic [31:0] exp_rd;
    logic [3:0]  wd;
    bit exp_err, is_ram;
    int exp_lat, samp, en0;
    exp_rd = 32'd0; exp_err = 1'b0; is_ram = 1'b0; exp_lat = 1;
    got = 32'd0; lat = 0;
    samp = b2b ? 2 : 1;
    en0  = en_cnt[i];
    req_d[i] = 1'b1; we_d[i] = we; addr_d[i] = addr; wdata_d[i] = wdata;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == samp) begin
        wd = addr[5:2];
        case (addr[31:28])
          4'h0: begin
            is_ram  = 1'b1;
            exp_lat = 2 + wait_of[i];
            if (we) ref_mem[i][wd] = wdata;
            else exp_rd = ref_mem[i][wd];
          end
          4'hE: begin
            if (we) begin
              if (!addr[2]) ref_led[i] = wdata[15:0];
            end else begin
              exp_rd = addr[2] ? {16'd0, ref_led[i]} : {16'd0, sw};
            end
          end
          4'hF: begin
            if (we) begin
              tbase[i] = wdata;
              tcyc[i]  = cyc;
            end else begin
              exp_rd = tbase[i] + 32'(cyc - 1 - tcyc[i]);
            end
          end
          default: begin
            exp_err = 1'b1;
            exp_rd  = we ? 32'd0 : 32'hDEAD_BEEF;
          end
        endcase
        exp_lat = exp_lat + samp - 1;
        if (scram) begin
          addr_d[i]  = $urandom;
          wdata_d[i] = $urandom;
          we_d[i]    = 1'($urandom_range(0, 1));
        end
      end
      if (ready_v[i]) begin
        lat = e;
        got = rdata_v[i];
        break;
      end
      chk("rdata_not_done", rdata_v[i], 32'd0);
    end
    chk("latency", lat, exp_lat);
    chk("rdata", got, exp_rd);
    chk("bus_err", 32'(err_v[i]), 32'(exp_err));
    chk("ram_en_pulses", en_cnt[i] - en0, 32'(is_ram));
    chk("led_out", 32'(led_v[i]), 32'(ref_led[i]));
  endtask

  initial begin
    logic [31:0] got;
    int lat;
    bit open, b2b, we;
    int i, last_i, r;
    logic [31:0] a, d;

    rst_n = 1'b1;
    sw = 16'd0;
    for (int k = 0; k < 2; k++) begin
      req_d[k] = 1'b0; we_d[k] = 1'b0; addr_d[k] = 32'd0; wdata_d[k] = 32'd0;
      ref_led[k] = 16'd0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(ready_v[k]), 32'd0);
      chk("rst_err", 32'(err_v[k]), 32'd0);
      chk("rst_rdata", rdata_v[k], 32'd0);
      chk("rst_ram_en", 32'(ram_en_v[k]), 32'd0);
      chk("rst_ram_we", 32'(ram_we_v[k]), 32'd0);
      chk("rst_led", 32'(led_v[k]), 32'd0);
      chk("rst_int", 32'(int_v[k]), 32'd0);
    end
    rst_n = 1'b1;
    reset_model();
    idle(2);

    // Fill the 16 model words of both RAMs through aliased addresses.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        idle(1);
        xact(k, 1'b1, ram_a(w), $urandom, 1'b0, 1'b0, got, lat);
      end
    end

    // RAM write then read-back, RAM_WAIT=2
    idle(1);
    xact(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 1'b0, got, lat);
    chk("t1_wr_lat", lat, 32'd4);
    idle(1);
    xact(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, got, lat);
    chk("t1_rd_lat", lat, 32'd4);
    chk("t1_rd_data", got, 32'h1234_5678);

    // GPIO
    idle(1);
    xact(0, 1'b1, 32'hE000_0000, 32'hFFFF_A5A5, 1'b0, 1'b0, got, lat);
    chk("t2_led", 32'(led_v[0]), 32'h0000_A5A5);
    chk("t2_lat", lat, 32'd1);
    sw = 16'h00C3;
    idle(1);
    xact(0, 1'b0, 32'hE000_0000, 32'd0, 1'b0, 1'b0, got, lat);
    chk("t2_sw_read", got, 32'h0000_00C3);
    idle(1);
    xact(0, 1'b0, 32'hE000_0004, 32'd0, 1'b0, 1'b0, got, lat);
    chk("t2_led_read", got, 32'h0000_A5A5);

    // Timer load near wrap, then wrap interrupt
    idle(1);
    xact(0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFD, 1'b0, 1'b0, got, lat);
    chk("t3_no_int_on_load", 32'(int_v[0]), 32'd0);
    idle(3);
    chk("t3_wrap_int", 32'(int_v[0]), 32'd1);
    xact(0, 1'b0, 32'hF000_0000, 32'd0, 1'b0, 1'b0, got, lat);
    chk("t3_count0", got, 32'd0);
    chk("t3_int_single", 32'(int_v[0]), 32'd0);
    idle(1);
    xact(0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, got, lat);
    chk("t3_load_ffff_no_int", 32'(int_v[0]), 32'd0);
    idle(1);
    chk("t3_wrap_after_ffff", 32'(int_v[0]), 32'd1);

    // Unmapped
    idle(1);
    xact(0, 1'b0, 32'h5000_0000, 32'd0, 1'b0, 1'b0, got, lat);
    chk("t4_deadbeef", got, 32'hDEAD_BEEF);
    idle(1);
    xact(0, 1'b1, 32'h5000_0000, 32'h0BAD_F00D, 1'b0, 1'b0, got, lat);
    idle(1);
    xact(0, 1'b0, 32'hF000_0000, 32'd0, 1'b0, 1'b0, got, lat);
    idle(1);
    xact(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, got, lat);

    // Back-to-back with RAM_WAIT=0 and scrambled inputs mid-access
    idle(1);
    xact(1, 1'b0, ram_a(3), 32'd0, 1'b0, 1'b1, got, lat);
    chk("t6_lat", lat, 32'd2);
    xact(1, 1'b1, ram_a(5), 32'hCAFE_0005, 1'b1, 1'b1, got, lat);
    xact(1, 1'b0, ram_a(5), 32'd0, 1'b1, 1'b1, got, lat);
    chk("t6_readback", got, 32'hCAFE_0005);

    // Random traffic
    open = 1'b1;
    last_i = 1;
    for (int n = 0; n < 300; n++) begin
      i   = $urandom_range(0, 1);
      b2b = open && (i == last_i) && ($urandom_range(0, 1) == 1);
      if (!b2b) idle($urandom_range(1, 3));
      r  = $urandom_range(0, 99);
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      sw = 16'($urandom);
      if (r < 50) a = ram_a($urandom_range(0, 15));
      else if (r < 70) a = 32'hE000_0000 | 32'($urandom_range(0, 1) << 2) | 32'($urandom_range(0, 3));
      else if (r < 85) begin
        a = 32'hF000_0000 | 32'($urandom_range(0, 3));
        d = d & 32'h0FFF_FFFF;
      end else a = {4'($urandom_range(1, 13)), 28'($urandom)};
      xact(i, we, a, d, b2b, 1'($urandom_range(0, 1)), got, lat);
      open = 1'b1;
      last_i = i;
    end

    // Async reset during WAIT of a RAM write
    idle(1);
    xact(0, 1'b1, 32'hE000_0000, 32'h0000_5A5A, 1'b0, 1'b0, got, lat);
    idle(1);
    req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = ram_a(7); wdata_d[0] = 32'h7777_0007;
    @(posedge clk);
    #1;
    chk("t5_ram_en_access", 32'(ram_en_v[0]), 32'd1);
    chk("t5_ram_we_access", 32'(ram_we_v[0]), 32'd1);
    ref_mem[0][7] = 32'h7777_0007;
    @(posedge clk);
    #1;
    chk("t5_in_wait_ram_en", 32'(ram_en_v[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_ready_drop", 32'(ready_v[0]), 32'd0);
    chk("t5_ram_en_drop", 32'(ram_en_v[0]), 32'd0);
    chk("t5_ram_we_drop", 32'(ram_we_v[0]), 32'd0);
    chk("t5_led_drop", 32'(led_v[0]), 32'd0);
    chk("t5_rdata_zero", rdata_v[0], 32'd0);
    req_d[0] = 1'b0;
    req_d[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    idle(2);
    chk("t5_ready_after", 32'(ready_v[0]), 32'd0);
    chk("t5_led1_after", 32'(led_v[1]), 32'd0);
    xact(0, 1'b0, ram_a(7), 32'd0, 1'b0, 1'b0, got, lat);
    chk("t5_lat_idle_start", lat, 32'd4);
    idle(1);
    xact(0, 1'b0, 32'hF000_0000, 32'd0, 1'b0, 1'b0, got, lat);
    idle(1);
    xact(1, 1'b0, 32'hF000_0000, 32'd0, 1'b0, 1'b0, got, lat);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
